// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port memory between the instruction-fetch port and the
// data port of the core. Only one access is in flight at a time, and the
// read latency of the memory is covered by wait states. cpu_stall holds the
// core until every request it has raised has been acknowledged.

module unified_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,

    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              cpu_stall,
    output logic              grant_d
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    // Both counters are 4 bits wide because both limits are at most 15.
    localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              grant_d_q, grant_d_d;
    logic              is_wr_q, is_wr_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;

    logic              data_req;
    logic              fetch_forced;

    // A write wins over a read when both data strobes are high. Fetch is
    // forced ahead of data once it has been passed over STARVE_LIMIT times.
    assign data_req     = d_rd | d_wr;
    assign fetch_forced = if_req && (starve_cnt_q == STARVE_MAX);

    // Next-state and registered-output logic for the access sequencer.
    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        grant_d_d    = grant_d_q;
        is_wr_d      = is_wr_q;
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;

        case (state_q)
            IDLE: begin
                if (data_req && !fetch_forced) begin
                    state_d     = ISSUE;
                    grant_d_d   = 1'b1;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    is_wr_d     = d_wr;
                    mem_we_d    = d_wr;
                    mem_re_d    = ~d_wr;
                    if (!if_req) begin
                        starve_cnt_d = 4'd0;
                    end else if (starve_cnt_q != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (if_req) begin
                    state_d      = ISSUE;
                    grant_d_d    = 1'b0;
                    mem_addr_d   = if_addr;
                    is_wr_d      = 1'b0;
                    mem_re_d     = 1'b1;
                    starve_cnt_d = 4'd0;
                end else begin
                    starve_cnt_d = 4'd0;
                end
            end

            ISSUE: begin
                if (is_wr_q) begin
                    state_d = ACK;
                    d_ack_d = 1'b1;
                end else begin
                    state_d    = WAIT;
                    wait_cnt_d = WAIT_INIT;
                end
            end

            WAIT: begin
                if (wait_cnt_q <= 4'd1) begin
                    state_d    = ACK;
                    wait_cnt_d = 4'd0;
                    if (grant_d_q) begin
                        d_rdata_d = mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end

            ACK: begin
                state_d   = IDLE;
                grant_d_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; a low rst at a clock edge aborts any
    // transaction in flight without acknowledging it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            grant_d_q    <= 1'b0;
            is_wr_q      <= 1'b0;
            wait_cnt_q   <= 4'd0;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            grant_d_q    <= grant_d_d;
            is_wr_q      <= is_wr_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign grant_d   = grant_d_q;

    assign cpu_stall = (if_req & ~if_ack_q) | (data_req & ~d_ack_q);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter
// Directed bench: one arbiter with single-cycle memory latency and a short
// starvation limit, plus a second arbiter with three-cycle latency.

module tb_unified_mem_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Signals of the main instance (WAIT_CYCLES=1, STARVE_LIMIT=2)
    logic        ifReq, dRd, dWr;
    logic [15:0] ifAddr, dAddr, dWdata;
    logic [15:0] ifRdata, dRdata, memAddr, memWdata, memRdata;
    logic        ifAck, dAck, memRe, memWe, cpuStall, grantD;

    // Signals of the slow-memory instance (WAIT_CYCLES=3)
    logic        wIfReq, wdRd, wdWr;
    logic [15:0] wIfAddr, wdAddr, wdWdata;
    logic [15:0] wIfRdata, wdRdata, wMemAddr, wMemWdata, wMemRdata;
    logic        wIfAck, wdAck, wMemRe, wMemWe, wCpuStall, wGrantD;

    int compared   = 0;
    int mismatched = 0;

    unified_mem_arbiter #(
        .ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1), .STARVE_LIMIT(2)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_ack(ifAck),
        .d_rd(dRd), .d_wr(dWr), .d_addr(dAddr), .d_wdata(dWdata),
        .d_rdata(dRdata), .d_ack(dAck),
        .mem_addr(memAddr), .mem_wdata(memWdata), .mem_re(memRe), .mem_we(memWe),
        .mem_rdata(memRdata), .cpu_stall(cpuStall), .grant_d(grantD)
    );

    unified_mem_arbiter #(
        .ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3), .STARVE_LIMIT(4)
    ) dutW (
        .clk(clk), .rst(rst),
        .if_req(wIfReq), .if_addr(wIfAddr), .if_rdata(wIfRdata), .if_ack(wIfAck),
        .d_rd(wdRd), .d_wr(wdWr), .d_addr(wdAddr), .d_wdata(wdWdata),
        .d_rdata(wdRdata), .d_ack(wdAck),
        .mem_addr(wMemAddr), .mem_wdata(wMemWdata), .mem_re(wMemRe), .mem_we(wMemWe),
        .mem_rdata(wMemRdata), .cpu_stall(wCpuStall), .grant_d(wGrantD)
    );

    // Memory behind the main instance: data is valid exactly one cycle
    // after the read strobe and garbage otherwise.
    logic [15:0] memArr [0:255];
    logic [3:0]  pend = 4'd0;
    logic [7:0]  rdAddr = 8'd0;
    logic        loadMem = 1'b0;

    always @(posedge clk) begin
        if (loadMem) begin
            for (int i = 0; i < 256; i++) memArr[i] <= {8'h5A, 8'(i)};
            memArr[8'h04] <= 16'h1111;
            memArr[8'h10] <= 16'hA5A5;
            memArr[8'h20] <= 16'h2222;
        end else if (memWe) begin
            memArr[memAddr[7:0]] <= memWdata;
        end
        if (memRe) begin
            pend   <= 4'd1;
            rdAddr <= memAddr[7:0];
        end else if (pend != 4'd0) begin
            pend <= pend - 4'd1;
        end
    end

    assign memRdata = (pend == 4'd1) ? memArr[rdAddr] : 16'hDEAD;

    // Memory behind the slow instance: three cycles of latency, with a
    // different garbage value in each cycle before the data is valid.
    logic [3:0] pendW = 4'd0;
    logic [7:0] wRdAddr = 8'd0;

    always @(posedge clk) begin
        if (wMemRe) begin
            pendW   <= 4'd3;
            wRdAddr <= wMemAddr[7:0];
        end else if (pendW != 4'd0) begin
            pendW <= pendW - 4'd1;
        end
    end

    assign wMemRdata = (pendW == 4'd1) ? {8'hC3, wRdAddr} : {12'hDEA, pendW};

    typedef struct {
        logic [2:0]  req;      // {if_req, d_rd, d_wr}
        logic [15:0] ifAddr;
        logic [15:0] dAddr;
        logic [15:0] dWdata;
        logic [5:0]  eOut;     // {mem_re, mem_we, if_ack, d_ack, grant_d, cpu_stall}
        logic        chkIf;
        logic [15:0] eIfData;
        logic        chkD;
        logic [15:0] eDData;
        logic        chkAddr;
        logic [15:0] eAddr;
        logic        chkWdata;
        logic [15:0] eWdata;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [2:0] req, input logic [15:0] ia,
                                input logic [15:0] da, input logic [15:0] dw,
                                input logic [5:0] eOut);
        vec_t v;
        v.req      = req;
        v.ifAddr   = ia;
        v.dAddr    = da;
        v.dWdata   = dw;
        v.eOut     = eOut;
        v.chkIf    = 1'b0;
        v.eIfData  = 16'h0;
        v.chkD     = 1'b0;
        v.eDData   = 16'h0;
        v.chkAddr  = 1'b0;
        v.eAddr    = 16'h0;
        v.chkWdata = 1'b0;
        v.eWdata   = 16'h0;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {15'h0, actual}, {15'h0, expected});
    endtask

    task automatic applyStimulus(input vec_t v);
        ifReq  = v.req[2];
        dRd    = v.req[1];
        dWr    = v.req[0];
        ifAddr = v.ifAddr;
        dAddr  = v.dAddr;
        dWdata = v.dWdata;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic gotGrant [6];
        logic expGrant [6];
        logic expReW   [7];
        logic expAckW  [7];
        int   grants;
        int   cyc;
        logic ackSeen;

        // ------------------------------------------------------------
        // Vector table: simultaneous requests, write then read-back,
        // read+write collision, and a read of the collided address.
        // ------------------------------------------------------------
        vecs[0]  = mk(3'b110, 16'h0004, 16'h0020, 16'h0000, 6'b000001);
        vecs[1]  = mk(3'b110, 16'h0004, 16'h0020, 16'h0000, 6'b100011);
        vecs[2]  = mk(3'b110, 16'h0004, 16'h0020, 16'h0000, 6'b000011);
        vecs[3]  = mk(3'b100, 16'h0004, 16'h0020, 16'h0000, 6'b000111);
        vecs[3].chkD = 1'b1; vecs[3].eDData = 16'h2222;
        vecs[4]  = mk(3'b100, 16'h0004, 16'h0000, 16'h0000, 6'b000001);
        vecs[5]  = mk(3'b100, 16'h0004, 16'h0000, 16'h0000, 6'b100001);
        vecs[5].chkAddr = 1'b1; vecs[5].eAddr = 16'h0004;
        vecs[6]  = mk(3'b100, 16'h0004, 16'h0000, 16'h0000, 6'b000001);
        vecs[7]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 6'b001000);
        vecs[7].chkIf = 1'b1; vecs[7].eIfData = 16'h1111;
        vecs[8]  = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 6'b000000);
        vecs[9]  = mk(3'b001, 16'h0000, 16'h0030, 16'hBEEF, 6'b000001);
        vecs[10] = mk(3'b001, 16'h0000, 16'h0030, 16'hBEEF, 6'b010011);
        vecs[10].chkAddr = 1'b1;  vecs[10].eAddr  = 16'h0030;
        vecs[10].chkWdata = 1'b1; vecs[10].eWdata = 16'hBEEF;
        vecs[11] = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 6'b000110);
        vecs[12] = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 6'b000000);
        vecs[13] = mk(3'b010, 16'h0000, 16'h0030, 16'h0000, 6'b000001);
        vecs[14] = mk(3'b010, 16'h0000, 16'h0030, 16'h0000, 6'b100011);
        vecs[14].chkAddr = 1'b1; vecs[14].eAddr = 16'h0030;
        vecs[15] = mk(3'b010, 16'h0000, 16'h0030, 16'h0000, 6'b000011);
        vecs[16] = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 6'b000110);
        vecs[16].chkD = 1'b1; vecs[16].eDData = 16'hBEEF;
        vecs[17] = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 6'b000000);
        vecs[18] = mk(3'b011, 16'h0000, 16'h0040, 16'h1234, 6'b000001);
        vecs[19] = mk(3'b011, 16'h0000, 16'h0077, 16'hFFFF, 6'b010011);
        vecs[19].chkAddr = 1'b1;  vecs[19].eAddr  = 16'h0040;
        vecs[19].chkWdata = 1'b1; vecs[19].eWdata = 16'h1234;
        vecs[20] = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 6'b000110);
        vecs[20].chkD = 1'b1; vecs[20].eDData = 16'hBEEF;
        vecs[21] = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 6'b000000);
        vecs[22] = mk(3'b010, 16'h0000, 16'h0040, 16'h0000, 6'b000001);
        vecs[23] = mk(3'b010, 16'h0000, 16'h0040, 16'h0000, 6'b100011);
        vecs[24] = mk(3'b010, 16'h0000, 16'h0040, 16'h0000, 6'b000011);
        vecs[25] = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 6'b000110);
        vecs[25].chkD = 1'b1; vecs[25].eDData = 16'h1234;
        vecs[26] = mk(3'b000, 16'h0000, 16'h0000, 16'h0000, 6'b000000);

        expGrant = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        expReW   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        expAckW  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // ------------------------------------------------------------
        // Power-on reset
        // ------------------------------------------------------------
        rst = 1'b0; loadMem = 1'b1;
        ifReq = 1'b0; dRd = 1'b0; dWr = 1'b0;
        ifAddr = 16'h0; dAddr = 16'h0; dWdata = 16'h0;
        wIfReq = 1'b0; wdRd = 1'b0; wdWr = 1'b0;
        wIfAddr = 16'h0; wdAddr = 16'h0; wdWdata = 16'h0;
        repeat (3) nextCycle();
        loadMem = 1'b0;
        @(negedge clk);
        checkOutput("rst_mem_addr", memAddr, 16'h0);
        checkOutput("rst_mem_wdata", memWdata, 16'h0);
        checkBit("rst_mem_re", memRe, 1'b0);
        checkBit("rst_mem_we", memWe, 1'b0);
        checkOutput("rst_if_rdata", ifRdata, 16'h0);
        checkOutput("rst_d_rdata", dRdata, 16'h0);
        checkBit("rst_if_ack", ifAck, 1'b0);
        checkBit("rst_d_ack", dAck, 1'b0);
        checkBit("rst_grant_d", grantD, 1'b0);
        checkBit("rst_w_mem_re", wMemRe, 1'b0);
        checkOutput("rst_w_d_rdata", wdRdata, 16'h0);
        nextCycle();
        rst = 1'b1;
        nextCycle();

        // ------------------------------------------------------------
        // Reset while a fetch read sits in WAIT
        // ------------------------------------------------------------
        ifReq = 1'b1; ifAddr = 16'h0004;
        @(negedge clk); checkBit("abort_c0_stall", cpuStall, 1'b1);
        nextCycle();
        @(negedge clk); checkBit("abort_c1_mem_re", memRe, 1'b1);
        nextCycle();
        rst = 1'b0; ifReq = 1'b0;
        nextCycle();
        @(negedge clk);
        checkBit("abort_mem_re", memRe, 1'b0);
        checkBit("abort_if_ack", ifAck, 1'b0);
        checkBit("abort_grant_d", grantD, 1'b0);
        checkOutput("abort_if_rdata", ifRdata, 16'h0);
        nextCycle();
        rst = 1'b1;
        ackSeen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ifAck || dAck) ackSeen = 1'b1;
            nextCycle();
        end
        checkBit("abort_no_ack", ackSeen, 1'b0);

        ifReq = 1'b1; ifAddr = 16'h0010;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) ifReq = 1'b0;
            @(negedge clk);
            checkBit($sformatf("post_rst_c%0d_if_ack", c), ifAck, (c == 3));
            nextCycle();
        end
        checkOutput("post_rst_if_rdata", ifRdata, 16'hA5A5);
        nextCycle();

        // ------------------------------------------------------------
        // Table-driven sequences
        // ------------------------------------------------------------
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkBit($sformatf("v%0d_mem_re", i), memRe, vecs[i].eOut[5]);
            checkBit($sformatf("v%0d_mem_we", i), memWe, vecs[i].eOut[4]);
            checkBit($sformatf("v%0d_if_ack", i), ifAck, vecs[i].eOut[3]);
            checkBit($sformatf("v%0d_d_ack", i), dAck, vecs[i].eOut[2]);
            checkBit($sformatf("v%0d_grant_d", i), grantD, vecs[i].eOut[1]);
            checkBit($sformatf("v%0d_cpu_stall", i), cpuStall, vecs[i].eOut[0]);
            if (vecs[i].chkIf)
                checkOutput($sformatf("v%0d_if_rdata", i), ifRdata, vecs[i].eIfData);
            if (vecs[i].chkD)
                checkOutput($sformatf("v%0d_d_rdata", i), dRdata, vecs[i].eDData);
            if (vecs[i].chkAddr)
                checkOutput($sformatf("v%0d_mem_addr", i), memAddr, vecs[i].eAddr);
            if (vecs[i].chkWdata)
                checkOutput($sformatf("v%0d_mem_wdata", i), memWdata, vecs[i].eWdata);
            nextCycle();
        end

        // ------------------------------------------------------------
        // Starvation: both ports request continuously, limit of 2
        // ------------------------------------------------------------
        ifReq = 1'b1; ifAddr = 16'h0004;
        dRd = 1'b1; dWr = 1'b0; dAddr = 16'h0020;
        grants = 0;
        cyc = 0;
        while (grants < 6 && cyc < 80) begin
            @(negedge clk);
            if (memRe) begin
                gotGrant[grants] = grantD;
                grants++;
            end
            nextCycle();
            cyc++;
        end
        checkOutput("starve_grant_count", 16'(grants), 16'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < grants)
                checkBit($sformatf("starve_grant%0d_is_data", k), gotGrant[k], expGrant[k]);
        end
        ifReq = 1'b0; dRd = 1'b0;
        repeat (8) nextCycle();

        // ------------------------------------------------------------
        // Three-cycle memory latency with garbage before valid data
        // ------------------------------------------------------------
        wdRd = 1'b1; wdAddr = 16'h0008;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) wdRd = 1'b0;
            @(negedge clk);
            checkBit($sformatf("w3_c%0d_mem_re", c), wMemRe, expReW[c]);
            checkBit($sformatf("w3_c%0d_d_ack", c), wdAck, expAckW[c]);
            if (c >= 5)
                checkOutput($sformatf("w3_c%0d_d_rdata", c), wdRdata, 16'hC308);
            nextCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Single-port memory controller and arbiter that shares one 16-bit unified memory between the core's instruction-fetch port and data port.
- Sits between cpu_core (pc_out/instr_out and mem_rd/mem_wr/alu_Out/reg_Data_2/mem_Data_in) and the memory macro.
- Serialises accesses, inserts memory wait states, and raises a stall so the core holds its state until both of its accesses for the current instruction complete.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- WAIT_CYCLES, 1, read latency of the memory in cycles (mem_re to valid mem_rdata); legal range 1..15.
- STARVE_LIMIT, 4, maximum consecutive data grants while if_req is pending before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word, registered, valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse for fetch.
- d_rd  in  1  data read request, held until d_ack.
- d_wr  in  1  data write request, held until d_ack.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data, registered, valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse for data.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_re  out  1  memory read strobe, registered.
- mem_we  out  1  memory write strobe, registered.
- mem_rdata  in  DATA_W  memory read data.
- cpu_stall  out  1  combinational: (if_req & ~if_ack) | ((d_rd|d_wr) & ~d_ack).
- grant_d  out  1  registered: 1 while the data port owns the current transaction.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state goes to IDLE.
  - All registered outputs go to 0: mem_addr, mem_wdata, mem_re, mem_we, if_rdata, d_rdata, if_ack, d_ack, grant_d.
  - Starvation counter and wait counter clear.
  - Reset mid-transaction aborts it with no ack.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: requests are sampled only in this state.
  - Priority is data > fetch, except fetch wins when starve_cnt == STARVE_LIMIT and if_req=1.
  - On grant, latch address and wdata, set grant_d, and go to ISSUE.
  - A write grant drives mem_we=1 in ISSUE; a read grant drives mem_re=1.
- ISSUE: lasts exactly one cycle, with the strobe high.
  - Write: go to ACK.
  - Read: go to WAIT with wait_cnt = WAIT_CYCLES.
- WAIT: decrement wait_cnt each cycle.
  - In the cycle where wait_cnt == 1, mem_rdata is valid.
  - At that edge, capture mem_rdata into if_rdata or d_rdata, pulse the matching ack, and go to ACK.
- ACK: lasts one cycle, with the ack high and strobes low.
  - Clear grant_d and return to IDLE.
  - Requests are not sampled in ACK; the requester deasserts or changes its request during this cycle.
- Latency, read (request first seen in cycle 0, IDLE): ISSUE in cycle 1, ack in cycle 2+WAIT_CYCLES.
- Latency, write: ack in cycle 2.
- Throughput: at most one transaction per (3+WAIT_CYCLES) cycles for reads and 3 cycles for writes.
- Starvation counter:
  - Increments on each data grant made while if_req=1.
  - Saturates at STARVE_LIMIT.
  - Clears on any fetch grant or when if_req=0 in IDLE.
- d_rd and d_wr both high: treated as a write; d_rd is ignored.
- Address or wdata changes after grant are ignored until the next grant.
- if_rdata and d_rdata hold their last captured value after ack; they update only on the matching capture.
- Idle bus: mem_re and mem_we are 0 in IDLE, WAIT and ACK.
- mem_addr and mem_wdata hold the last granted values.

Test Plan:
- Reset: rst=0 for 2 cycles mid-read (state WAIT) -> next cycle mem_re=0, if_ack=0, no ack ever issued; then if_req=1, if_addr=0x0010 with mem[0x10]=0xA5A5 -> if_ack in cycle 3, if_rdata=0xA5A5.
- Simultaneous: if_req and d_rd both asserted in cycle 0 at addrs 0x0004/0x0020 (mem=0x1111/0x2222) -> data served first, d_ack cycle 3 with d_rdata=0x2222; fetch ack cycle 7 with 0x1111; cpu_stall=1 through cycle 6, 0 in cycle 7.
- Write: d_wr=1, d_addr=0x0030, d_wdata=0xBEEF -> mem_we=1 in cycle 1 only, d_ack cycle 2; subsequent read of 0x0030 returns 0xBEEF.
- Starvation: STARVE_LIMIT=2, d_rd re-requested continuously while if_req held -> grant order D, D, F, D, D, F.
- WAIT_CYCLES=3: read request in cycle 0 -> mem_re high only in cycle 1, ack in cycle 5; mem_rdata glitches in cycles 2-3 are not captured.
- d_rd=d_wr=1: mem_we=1, mem_re=0 throughout the transaction, d_ack in cycle 2.
